cdb_arbiter: RTL



---
 rtl/cdb_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Purpose: round-robin arbiter that shares the common data bus (CDB) between execution units.
// Latency: one cycle from a grant (req_valid & req_ready) to the registered cdb/cdb_valid broadcast.
// Backpressure: none on the bus; requesters hold valid/data until req_ready, with a starvation watchdog.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   flush       branch miss: blocks grants this cycle, so nothing is broadcast next cycle
//   req_valid   per-unit request (0 = ALU, 1 = MFU, 2 = MMU return path)
//   req_data    per-unit {rsv_id, data} word, unit i at [i*CDB_W +: CDB_W]
//   req_ready   per-unit grant, one-hot or zero, combinational
//   cdb         registered broadcast word
//   cdb_valid   cdb holds a valid result this cycle
//   starve_err  sticky: some requester waited longer than MAX_WAIT cycles
//
// Build option: define CDB_ARB_FIXED_PRIO_EN for lowest-index-wins priority
// (no round-robin pointer); the starvation watchdog is the same in both builds.
module cdb_arbiter #(
    parameter int N_UNITS  = 3,
    parameter int RSV_ID_W = 5,
    parameter int DATA_W   = 32,
    parameter int CDB_W    = RSV_ID_W + DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [N_UNITS-1:0]       req_valid,
    input  logic [N_UNITS*CDB_W-1:0] req_data,
    output logic [N_UNITS-1:0]       req_ready,
    output logic [CDB_W-1:0]         cdb,
    output logic                     cdb_valid,
    output logic                     starve_err
);

    localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    // Counter must be able to hold MAX_WAIT+1, the saturation value that flags starvation.
    localparam int CNT_W = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WAIT + 1);

    logic [N_UNITS-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               xfer;
    logic [CDB_W-1:0]   sel_data;
    logic [CNT_W-1:0]   wait_cnt [N_UNITS];
    logic               any_sat;

`ifdef CDB_ARB_FIXED_PRIO_EN
    // Lowest valid index wins; scanning downward leaves the lowest one last.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_idx = PTR_W'(i);
                grant_any = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;

    // Search from rr_ptr upward modulo N_UNITS. Scanning offsets downward
    // leaves the smallest offset (closest to rr_ptr) as the final winner.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = N_UNITS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_UNITS) begin
                idx = idx - N_UNITS;
            end
            if (req_valid[idx]) begin
                grant_idx = PTR_W'(idx);
                grant_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (grant_idx == PTR_W'(N_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end
`endif

    assign grant     = grant_any ? (N_UNITS'(1) << grant_idx) : '0;
    // Reset and flush both suppress the grant; ready therefore implies valid.
    assign req_ready = (rst | flush) ? '0 : grant;
    assign xfer      = |req_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*CDB_W +: CDB_W];
            end
        end
    end

    // Broadcast register: no transfer (including flush) leaves cdb_valid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb       <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= xfer;
            if (xfer) begin
                cdb <= sel_data;
            end
        end
    end

    // Wait counters: freeze during flush so a branch miss does not count as starvation.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (rst) begin
                wait_cnt[i] <= '0;
            end else if (!flush) begin
                if (!req_valid[i] || req_ready[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CNT_SAT) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        any_sat = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (wait_cnt[i] == CNT_SAT) begin
                any_sat = 1'b1;
            end
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_err <= 1'b0;
        end else if (any_sat) begin
            starve_err <= 1'b1;
        end
    end

endmodule
